// File: rtl/mmio_initiator.sv
// mmio_initiator: queued read/write/poll commands driven onto the MMIO bus, one response per command.
// Latency: bus strobe 2 cycles after the command handshake, response 1 cycle later; 3 cycles/command.
// Backpressure: cmd_ready drops when the command FIFO is full; FSM holds in RESP until rsp_ready.

// Generic synchronous FIFO with one extra pointer bit to tell full from empty.
module mmio_initiator_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Push and pop are independent, so both may happen in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

module mmio_initiator #(
  parameter int DEPTH      = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);
  localparam int CW = $clog2(POLL_LIMIT) + 1;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_POLL, S_RESP} state_t;

  state_t         state_q;
  logic [1:0]     work_op_q;
  logic [31:0]    work_data_q;
  logic [31:0]    work_mask_q;
  logic [CW-1:0]  poll_cnt_q;
  logic [CW-1:0]  poll_cnt_d;
  logic           rd_q;
  logic           wr_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_data_q;
  logic           rsp_err_q;

  cmd_t           push_cmd;
  cmd_t           head_cmd;
  logic [$bits(cmd_t)-1:0] head_raw;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           poll_match;
  logic           poll_last;

  assign push_cmd = '{op: cmd_op, addr: cmd_addr, data: cmd_data, mask: cmd_mask};
  assign head_cmd = cmd_t'(head_raw);

  // The FSM takes the head only from IDLE, so a command occupies the working registers
  // while up to DEPTH more wait in the FIFO.
  assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

  mmio_initiator_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_valid),
    .push_dat_i (push_cmd),
    .pop_i      (fifo_pop),
    .head_dat_o (head_raw),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Poll compare on the combinational read data of the current rd cycle.
  assign poll_match = ((rdata & work_mask_q) == (work_data_q & work_mask_q));
  assign poll_last  = (poll_cnt_q == CW'(POLL_LIMIT - 1));
  assign poll_cnt_d = poll_cnt_q + 1'b1;

  assign cmd_ready = !fifo_full;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

  // Command sequencer: all bus and response outputs are registered here, and every exit from
  // a strobe cycle clears addr/wdata so the bus is quiet whenever no strobe is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      work_op_q   <= OP_RD;
      work_data_q <= '0;
      work_mask_q <= '0;
      poll_cnt_q  <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            work_op_q   <= head_cmd.op;
            work_data_q <= head_cmd.data;
            work_mask_q <= head_cmd.mask;
            if (head_cmd.op == OP_RSVD) begin
              // Reserved op is answered with an error and never touches the bus.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              addr_q  <= head_cmd.addr;
              if (head_cmd.op == OP_WR) begin
                wr_q    <= 1'b1;
                wdata_q <= head_cmd.data;
              end else begin
                rd_q <= 1'b1;
              end
            end
          end
        end

        S_ISSUE: begin
          case (work_op_q)
            OP_WR: begin
              wr_q        <= 1'b0;
              addr_q      <= '0;
              wdata_q     <= '0;
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
            end
            OP_RD: begin
              rd_q        <= 1'b0;
              addr_q      <= '0;
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rdata;
              rsp_err_q   <= 1'b0;
            end
            OP_POLL: begin
              if (poll_match || (POLL_LIMIT == 1)) begin
                rd_q        <= 1'b0;
                addr_q      <= '0;
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rdata;
                rsp_err_q   <= !poll_match;
              end else begin
                // rd stays asserted so the next read follows without a gap.
                poll_cnt_q <= CW'(1);
                state_q    <= S_POLL;
              end
            end
            default: begin
              rd_q        <= 1'b0;
              wr_q        <= 1'b0;
              addr_q      <= '0;
              wdata_q     <= '0;
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
            end
          endcase
        end

        S_POLL: begin
          if (poll_match || poll_last) begin
            // poll_cnt_q counts reads already done, so this read is number poll_cnt_q+1.
            rd_q        <= 1'b0;
            addr_q      <= '0;
            poll_cnt_q  <= '0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rdata;
            rsp_err_q   <= !poll_match;
          end else begin
            poll_cnt_q <= poll_cnt_d;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule
